bf16_accumulator: RTL

Reduction stage directly downstream of the BF16 multiplier in the PU datapath. Accepts a stream of BF16 products over a valid/ready handshake, sums them into a running BF16 accumulator (one product per cycle), and emits the sum when the stream's last element arrives. The result is held until the consumer (NoC output port) accepts it.

---
 rtl/bf16_pkg.sv | 42 ++++
 rtl/bf16_adder.sv | 106 ++++++++++
 rtl/bf16_accumulator.sv | 97 +++++++++
 3 files changed

// File: rtl/bf16_pkg.sv
// Shared BF16 definitions: field constants, unpacked operand view, accumulator FSM states.
package bf16_pkg;

    localparam logic [7:0]  EXP_MAX = 8'd255;
    localparam logic [7:0]  BIAS    = 8'd127;
    localparam logic [15:0] QNAN    = 16'h7FC0;
    localparam logic [15:0] POS_INF = 16'h7F80;
    localparam logic [15:0] NEG_INF = 16'hFF80;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [7:0] sig;
    } bf16_unpacked_t;

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } acc_state_t;

    function automatic bf16_unpacked_t bf16_unpack(input logic [15:0] v);
        bf16_unpacked_t u;
        u.sign = v[15];
        u.exp  = v[14:7];
        u.sig  = {(v[14:7] != 8'd0), v[6:0]};
        return u;
    endfunction

    // Denormals flush to signed zero; any NaN collapses to the canonical quiet NaN.
    function automatic logic [15:0] bf16_canon(input logic [15:0] v);
        logic [15:0] r;
        if ((v[14:7] == EXP_MAX) && (v[6:0] != 7'd0)) begin
            r = QNAN;
        end else if (v[14:7] == 8'd0) begin
            r = {v[15], 15'd0};
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/bf16_adder.sv
// Combinational BF16 adder: FTZ, truncating, 11-bit aligned significand datapath.
module bf16_adder
    import bf16_pkg::*;
(
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    output logic [15:0] o_sum
);

    bf16_unpacked_t    w_ux;
    bf16_unpacked_t    w_uy;
    bf16_unpacked_t    w_a;
    bf16_unpacked_t    w_b;
    logic [7:0]        w_diff;
    logic [10:0]       w_sig_a;
    logic [10:0]       w_sig_b;
    logic [11:0]       w_raw;
    logic [3:0]        w_lz;
    logic signed [9:0] w_exp;
    logic [6:0]        w_frac;
    logic              w_x_nan;
    logic              w_y_nan;
    logic              w_x_inf;
    logic              w_y_inf;
    logic              w_x_zero;
    logic              w_y_zero;

    function automatic logic [3:0] lead_zeros(input logic [10:0] v);
        logic [3:0] lz;
        lz = 4'd0;
        for (int i = 0; i < 11; i++) begin
            if (v[i]) begin
                lz = 4'(10 - i);
            end
        end
        return lz;
    endfunction

    assign w_ux     = bf16_unpack(i_x);
    assign w_uy     = bf16_unpack(i_y);
    assign w_x_nan  = (i_x[14:7] == EXP_MAX) && (i_x[6:0] != 7'd0);
    assign w_y_nan  = (i_y[14:7] == EXP_MAX) && (i_y[6:0] != 7'd0);
    assign w_x_inf  = (i_x[14:7] == EXP_MAX) && (i_x[6:0] == 7'd0);
    assign w_y_inf  = (i_y[14:7] == EXP_MAX) && (i_y[6:0] == 7'd0);
    assign w_x_zero = (i_x[14:7] == 8'd0);
    assign w_y_zero = (i_y[14:7] == 8'd0);

    // Align, add/subtract and normalize the finite, non-zero case.
    always_comb begin
        if (i_y[14:0] > i_x[14:0]) begin
            w_a = w_uy;
            w_b = w_ux;
        end else begin
            w_a = w_ux;
            w_b = w_uy;
        end
        w_diff  = w_a.exp - w_b.exp;
        w_sig_a = {w_a.sig, 3'b000};
        if (w_diff >= 8'd11) begin
            w_sig_b = 11'd0;
        end else begin
            w_sig_b = {w_b.sig, 3'b000} >> w_diff;
        end
        if (w_a.sign == w_b.sign) begin
            w_raw = {1'b0, w_sig_a} + {1'b0, w_sig_b};
        end else begin
            w_raw = {1'b0, w_sig_a} - {1'b0, w_sig_b};
        end
        w_lz = lead_zeros(w_raw[10:0]);
        if (w_raw[11]) begin
            w_exp  = $signed({2'b00, w_a.exp}) + 10'sd1;
            w_frac = 7'(w_raw >> 4);
        end else begin
            w_exp  = $signed({2'b00, w_a.exp}) - $signed({6'd0, w_lz});
            w_frac = 7'((w_raw[10:0] << w_lz) >> 3);
        end
    end

    // Special-operand priority, then range checks on the 10-bit exponent.
    always_comb begin
        if (w_x_nan || w_y_nan) begin
            o_sum = QNAN;
        end else if (w_x_inf && w_y_inf && (i_x[15] != i_y[15])) begin
            o_sum = QNAN;
        end else if (w_x_inf) begin
            o_sum = i_x;
        end else if (w_y_inf) begin
            o_sum = i_y;
        end else if (w_x_zero && w_y_zero) begin
            o_sum = {(i_x[15] & i_y[15]), 15'd0};
        end else if (w_x_zero) begin
            o_sum = i_y;
        end else if (w_y_zero) begin
            o_sum = i_x;
        end else if (w_raw == 12'd0) begin
            o_sum = 16'h0000;
        end else if (w_exp >= 10'sd255) begin
            o_sum = {w_a.sign, 8'hFF, 7'h00};
        end else if (w_exp <= 10'sd0) begin
            o_sum = {w_a.sign, 15'd0};
        end else begin
            o_sum = {w_a.sign, w_exp[7:0], w_frac};
        end
    end

endmodule

// File: rtl/bf16_accumulator.sv
// Streaming BF16 sum: accepts one product per cycle, presents the total on stream end.
module bf16_accumulator
    import bf16_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    acc_state_t       r_state;
    logic             r_first;
    logic [15:0]      r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;

    logic             w_fire;
    logic [15:0]      w_sum;
    logic [15:0]      w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    bf16_adder u_adder (
        .i_x   (r_acc),
        .i_y   (in_data),
        .o_sum (w_sum)
    );

    assign w_fire    = in_valid && r_in_ready;
    assign w_acc_nxt = r_first ? bf16_canon(in_data) : w_sum;
    assign w_cnt_nxt = r_first ? CNT_ONE : (r_cnt + CNT_ONE);

    // Accumulate/present FSM; handshake flags are registered state decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_first     <= 1'b1;
            r_acc       <= 16'h0000;
            r_cnt       <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_fire) begin
                        r_acc   <= w_acc_nxt;
                        r_cnt   <= w_cnt_nxt;
                        r_first <= 1'b0;
                        if (in_last || (w_cnt_nxt == CNT_MAX)) begin
                            r_state     <= ST_OUT;
                            r_in_ready  <= 1'b0;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_in_ready <= 1'b1;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_state     <= ST_ACC;
                        r_first     <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end else begin
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_ACC;
                    r_first     <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_acc;
    assign out_count = r_cnt;

endmodule
